ex_muldiv_stage: RTL and testbench
==================================

EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; legal values 8..64, even.
REQ-002 Parameter REG_AD, default 5: destination register address width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream presents an operation.
REQ-006 in_ready  output  1  stage accepts the operation this cycle.
REQ-007 op  input  4  operation code, per REQ-013.
REQ-008 src_a, src_b  input  WIDTH each  operands (rs, rt or extended immediate).
REQ-009 dst  input  REG_AD  destination register address.
REQ-010 out_valid  output  1  registered result available to the MEM stage.
REQ-011 out_ready  input  1  MEM stage consumes the result.
REQ-012 result  output  WIDTH; out_dst  output  REG_AD; zero  output  1; overflow  output  1; busy  output  1 (mul/div sequencer active).

Function
REQ-013 op encoding: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT, 9 SLTU, 10 MULT, 11 MULTU, 12 DIV, 13 DIVU, 14 MFHI, 15 MFLO.
REQ-014 Transfer occurs on in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-015 FSM states IDLE, MUL, DIV; an accepted op 10/11 goes IDLE->MUL, op 12/13 goes IDLE->DIV, all other ops stay in IDLE.
REQ-016 Ops 0-9 and 14-15 load result/out_dst/zero/overflow registers on the accepting edge; out_valid rises the next cycle (latency 1).
REQ-017 ADD/SUB signed overflow sets overflow=1 and forces out_dst=0 (writeback suppressed); ADDU/SUBU wrap modulo 2^WIDTH with overflow=0.
REQ-018 SLT/SLTU produce 1 or 0 zero-extended to WIDTH; zero = (result == 0) for every op.
REQ-019 MUL: shift-add, one bit per cycle, WIDTH cycles; signed MULT negates operands, multiplies magnitudes, fixes sign; {HI,LO} = 2*WIDTH-bit product.
REQ-020 DIV: restoring, one quotient bit per cycle, WIDTH cycles; LO=quotient, HI=remainder; signed DIV truncates toward zero, remainder takes dividend sign.
REQ-021 Divide by zero: same latency, LO = all ones, HI = src_a.
REQ-022 On the final MUL/DIV cycle HI/LO update, FSM returns to IDLE and out_valid rises with result=0, out_dst=0; total latency WIDTH+1 cycles from acceptance.
REQ-023 busy = (state != IDLE); in_ready = 0 while busy.
REQ-024 MFHI/MFLO return the current HI/LO; an MFHI accepted in the cycle after a MUL/DIV completion returns the updated value.
REQ-025 While out_valid && !out_ready, result, out_dst, zero and overflow hold stable; out_valid clears on consumption unless a new op is accepted in the same cycle.

Reset
REQ-026 rst_n low asynchronously sets state=IDLE, out_valid=0, result=0, out_dst=0, zero=0, overflow=0, HI=0, LO=0, iteration counter=0.
REQ-027 Reset during MUL/DIV aborts the operation; no partial HI/LO update is retained.
REQ-028 After rst_n deasserts, in_ready=1 on the first clock edge.

Configuration
REQ-029 Macro EX_MULDIV_DIV_EN defined: DIV/DIVU behave per REQ-020/021.
REQ-030 Macro EX_MULDIV_DIV_EN undefined: no divider logic; DIV/DIVU complete with latency 1, HI/LO unchanged, overflow=1, out_dst=0.

Verification
REQ-031 ADD 0x7FFFFFFF+0x00000001, dst=3 -> next cycle out_valid=1, result=0x80000000, overflow=1, out_dst=0.
REQ-032 MULT 0xFFFFFFFE * 0x00000003, then MFHI, MFLO -> busy for 32 cycles; MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA.
REQ-033 DIV -7 / 2, then MFLO, MFHI -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 5/0 -> LO=0xFFFFFFFF, HI=0x00000005.
REQ-034 SUBU 5-5 with out_ready=0 for 4 cycles -> result=0, zero=1 held stable, in_ready=0 until consumption.
REQ-035 rst_n pulsed low at cycle 10 of a MULTU -> busy=0, out_valid=0, HI=LO=0 immediately; next MFLO returns 0.
REQ-036 WIDTH=16 build: MULTU 0xFFFF*0xFFFF -> latency 17 cycles, HI=0xFFFE, LO=0x0001.

Source files
------------

// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage: execute stage with a single-cycle ALU plus a sequential
// shift-add multiplier and restoring divider that write the HI/LO pair.
// Optional feature macro: EX_MULDIV_DIV_EN builds the divider. Without it,
// DIV/DIVU complete in one cycle with overflow set, writeback suppressed and
// HI/LO left untouched.

module ex_muldiv_stage #(
    parameter int WIDTH  = 32,
    parameter int REG_AD = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    input  logic [REG_AD-1:0] dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [REG_AD-1:0] out_dst,
    output logic              zero,
    output logic              overflow,
    output logic              busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_ADDU  = 4'd1,
        OP_SUB   = 4'd2,
        OP_SUBU  = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_NOR   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_MULT  = 4'd10,
        OP_MULTU = 4'd11,
        OP_DIV   = 4'd12,
        OP_DIVU  = 4'd13,
        OP_MFHI  = 4'd14,
        OP_MFLO  = 4'd15
    } op_e;

    state_e             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   opnd;     // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH-1:0] work;     // {partial product, multiplier} or {remainder, quotient}
    logic               neg_q;    // product / quotient must be negated at the end
`ifdef EX_MULDIV_DIV_EN
    logic               neg_r;    // remainder takes the dividend sign
    logic               div_zero; // divisor was zero; work upper half holds src_a
`endif

    op_e              op_c;
    logic             accept;
    logic             is_mul;
    logic             op_signed;
    logic             last_iter;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] mul_prod;

    assign op_c      = op_e'(op);
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op_c == OP_MULT) || (op_c == OP_MULTU);
    assign op_signed = (op_c == OP_MULT) || (op_c == OP_DIV);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    assign sum   = src_a + src_b;
    assign diff  = src_a - src_b;
    assign mag_a = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign mag_b = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // One shift-add step: add multiplicand when the multiplier LSB is set, shift right
    assign mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, work[WIDTH-1:1]};
    assign mul_prod = neg_q ? -mul_next : mul_next;

`ifdef EX_MULDIV_DIV_EN
    logic               is_div;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;

    assign is_div = (op_c == OP_DIV) || (op_c == OP_DIVU);

    // One restoring step: shift in the next dividend bit, keep the subtraction if non-negative
    assign div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd};
    assign div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
    assign div_q     = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    assign div_r     = neg_r ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
`endif

    // Single-cycle result and signed-overflow flag for the non-sequenced ops
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_c)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUBU: alu_res = diff;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_NOR:  alu_res = ~(src_a | src_b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
`ifndef EX_MULDIV_DIV_EN
            OP_DIV, OP_DIVU: alu_ovf = 1'b1;
`endif
            default: ;
        endcase
    end

    // Sequencer FSM, HI/LO, iteration datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd      <= '0;
            work      <= '0;
            neg_q     <= 1'b0;
`ifdef EX_MULDIV_DIV_EN
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
`endif
            out_valid <= 1'b0;
            result    <= '0;
            out_dst   <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            // A consumed result drops; any new result below overrides this
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            opnd  <= mag_a;
                            work  <= {{WIDTH{1'b0}}, mag_b};
                            neg_q <= op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            cnt   <= '0;
                            state <= MUL;
                        end
`ifdef EX_MULDIV_DIV_EN
                        else if (is_div) begin
                            opnd     <= mag_b;
                            div_zero <= (src_b == '0);
                            work     <= (src_b == '0) ? {src_a, {WIDTH{1'b0}}}
                                                      : {{WIDTH{1'b0}}, mag_a};
                            neg_q    <= op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            neg_r    <= op_signed && src_a[WIDTH-1];
                            cnt      <= '0;
                            state    <= DIV;
                        end
`endif
                        else begin
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            out_dst   <= alu_ovf ? '0 : dst;
                            zero      <= (alu_res == '0);
                            overflow  <= alu_ovf;
                        end
                    end
                end
                MUL: begin
                    work <= mul_next;
                    cnt  <= cnt + CW'(1);
                    if (last_iter) begin
                        hi_q      <= mul_prod[2*WIDTH-1:WIDTH];
                        lo_q      <= mul_prod[WIDTH-1:0];
                        cnt       <= '0;
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        result    <= '0;
                        out_dst   <= '0;
                        zero      <= 1'b1;
                        overflow  <= 1'b0;
                    end
                end
`ifdef EX_MULDIV_DIV_EN
                DIV: begin
                    // Divide-by-zero idles through the same cycle count with src_a parked in work
                    if (!div_zero) begin
                        work <= div_next;
                    end
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        hi_q      <= div_zero ? work[2*WIDTH-1:WIDTH] : div_r;
                        lo_q      <= div_zero ? {WIDTH{1'b1}} : div_q;
                        cnt       <= '0;
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        result    <= '0;
                        out_dst   <= '0;
                        zero      <= 1'b1;
                        overflow  <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Bench for ex_muldiv_stage: randomized ops checked against an arithmetic
// reference model (longint math), plus directed corner cases and a
// WIDTH=16 instance. Honours EX_MULDIV_DIV_EN the same way as the design.

module tb_ex_muldiv_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [4:0]  dst = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  out_dst;
    logic        zero;
    logic        overflow;
    logic        busy;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [3:0]  w_op = '0;
    logic [15:0] w_src_a = '0;
    logic [15:0] w_src_b = '0;
    logic [4:0]  w_dst = '0;
    logic        w_out_valid;
    logic [15:0] w_result;
    logic [4:0]  w_out_dst;
    logic        w_zero;
    logic        w_overflow;
    logic        w_busy;

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    ex_muldiv_stage #(.WIDTH(32), .REG_AD(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src_a(src_a), .src_b(src_b), .dst(dst),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_dst(out_dst), .zero(zero), .overflow(overflow), .busy(busy)
    );

    ex_muldiv_stage #(.WIDTH(16), .REG_AD(5)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .op(w_op), .src_a(w_src_a), .src_b(w_src_b), .dst(w_dst),
        .out_valid(w_out_valid), .out_ready(1'b1), .result(w_result),
        .out_dst(w_out_dst), .zero(w_zero), .overflow(w_overflow), .busy(w_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference ALU from the arithmetic definitions
    function automatic logic [31:0] alu_ref(input int o, input logic [31:0] a, input logic [31:0] b,
                                            output logic ovf);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ovf = 1'b0;
        case (o)
            0: begin s = sa + sb; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); return s[31:0]; end
            1: return a + b;
            2: begin s = sa - sb; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); return s[31:0]; end
            3: return a - b;
            4: return a & b;
            5: return a | b;
            6: return a ^ b;
            7: return ~(a | b);
            8: return (sa < sb) ? 32'd1 : 32'd0;
            9: return (a < b) ? 32'd1 : 32'd0;
            14: return m_hi;
            15: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [63:0] mul_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint p;
        if (sgn) p = longint'($signed(a)) * longint'($signed(b));
        else     p = longint'({32'b0, a}) * longint'({32'b0, b});
        return p;
    endfunction

`ifdef EX_MULDIV_DIV_EN
    function automatic logic [63:0] div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'({32'b0, a}) / longint'({32'b0, b});
            r = longint'({32'b0, a}) % longint'({32'b0, b});
        end
        return {r[31:0], q[31:0]};
    endfunction
`endif

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'($urandom_range(0, 7));
            3: return 32'hFFFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Present one op from a negedge; returns at the negedge after it was accepted
    task automatic send(input int o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        int unsigned n = 0;
        #1;
        while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout op=%0d in_ready=%b required=1", o, in_ready);
        end
        in_valid = 1'b1; op = 4'(o); src_a = a; src_b = b; dst = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        total++; if (out_dst !== 5'd0 || zero !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL reset_flags got dst=%0d zero=%b ovf=%b exp all 0", out_dst, zero, overflow); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        send(15, 32'd0, 32'd0, 5'd1);
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", result); end
    endtask

    task automatic test_add_overflow();
        send(0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addovf_valid got=%b exp=1", out_valid); end
        total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL addovf_result got=%h exp=80000000", result); end
        total++; if (overflow !== 1'b1 || out_dst !== 5'd0) begin
            bad++; $display("FAIL addovf_flags got ovf=%b dst=%0d exp ovf=1 dst=0", overflow, out_dst); end
    endtask

    task automatic test_alu_random();
        int o;
        logic [31:0] a, b, exp;
        logic [4:0] d;
        logic ovf;
        for (int i = 0; i < 40; i++) begin
            o = ($urandom_range(0, 5) == 0) ? 14 + $urandom_range(0, 1) : $urandom_range(0, 9);
            a = rnd_opnd(); b = rnd_opnd(); d = 5'($urandom);
            exp = alu_ref(o, a, b, ovf);
            send(o, a, b, d);
            total++; if (out_valid !== 1'b1 || result !== exp) begin
                bad++; $display("FAIL alu_result op=%0d a=%h b=%h got=%h v=%b exp=%h", o, a, b, result, out_valid, exp); end
            total++; if (overflow !== ovf || out_dst !== (ovf ? 5'd0 : d) || zero !== (exp == 32'd0)) begin
                bad++; $display("FAIL alu_flags op=%0d got ovf=%b dst=%0d z=%b exp ovf=%b dst=%0d z=%b",
                                o, overflow, out_dst, zero, ovf, ovf ? 5'd0 : d, exp == 32'd0); end
        end
    endtask

    task automatic test_back_to_back();
        int o;
        logic [31:0] a, b, pexp;
        logic [4:0] d, pdst;
        logic ovf, povf;
        pexp = '0; pdst = '0; povf = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) begin
                total++; if (out_valid !== 1'b1 || result !== pexp || out_dst !== pdst || overflow !== povf) begin
                    bad++; $display("FAIL b2b_result idx=%0d got v=%b r=%h d=%0d o=%b exp r=%h d=%0d o=%b",
                                    i, out_valid, result, out_dst, overflow, pexp, pdst, povf); end
            end
            if (i < 20) begin
                #1;
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready idx=%0d got=%b exp=1", i, in_ready); end
                o = $urandom_range(0, 9); a = rnd_opnd(); b = rnd_opnd(); d = 5'($urandom);
                pexp = alu_ref(o, a, b, ovf); povf = ovf; pdst = ovf ? 5'd0 : d;
                in_valid = 1'b1; op = 4'(o); src_a = a; src_b = b; dst = d;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_mult();
        int unsigned n;
        logic held;
        logic [63:0] p;
        send(10, 32'hFFFF_FFFE, 32'h0000_0003, 5'd9);
        n = 0; held = 1'b1;
        while (busy && n < 200) begin if (in_ready !== 1'b0) held = 1'b0; @(negedge clk); n++; end
        total++; if (n != 32) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=32", n); end
        total++; if (!held) begin bad++; $display("FAIL mult_in_ready_busy got=1 exp=0"); end
        total++; if (out_valid !== 1'b1 || result !== 32'd0 || out_dst !== 5'd0) begin
            bad++; $display("FAIL mult_done got v=%b r=%h d=%0d exp v=1 r=0 d=0", out_valid, result, out_dst); end
        p = mul_ref(1'b1, 32'hFFFF_FFFE, 32'h0000_0003);
        m_hi = p[63:32]; m_lo = p[31:0];
        send(14, 32'd0, 32'd0, 5'd2);
        total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_mfhi got=%h exp=ffffffff", result); end
        send(15, 32'd0, 32'd0, 5'd2);
        total++; if (result !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_mflo got=%h exp=fffffffa", result); end
    endtask

    task automatic test_mul_random();
        int unsigned n;
        bit sgn;
        logic [31:0] a, b;
        logic [63:0] p;
        for (int i = 0; i < 8; i++) begin
            sgn = 1'($urandom); a = rnd_opnd(); b = rnd_opnd();
            p = mul_ref(sgn, a, b);
            send(sgn ? 10 : 11, a, b, 5'd4);
            n = 0;
            while (busy && n < 200) begin @(negedge clk); n++; end
            total++; if (n != 32) begin bad++; $display("FAIL mulr_cycles got=%0d exp=32", n); end
            m_hi = p[63:32]; m_lo = p[31:0];
            send(14, 32'd0, 32'd0, 5'd1);
            total++; if (result !== p[63:32]) begin bad++; $display("FAIL mulr_hi s=%0d a=%h b=%h got=%h exp=%h", sgn, a, b, result, p[63:32]); end
            send(15, 32'd0, 32'd0, 5'd1);
            total++; if (result !== p[31:0]) begin bad++; $display("FAIL mulr_lo s=%0d a=%h b=%h got=%h exp=%h", sgn, a, b, result, p[31:0]); end
        end
    endtask

    task automatic test_div();
`ifdef EX_MULDIV_DIV_EN
        int unsigned n;
        bit sgn;
        logic [31:0] a, b;
        logic [63:0] q;
        logic [3:0]  v_op [4] = '{4'd12, 4'd13, 4'd12, 4'd13};
        logic [31:0] v_a  [4] = '{32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'd100};
        logic [31:0] v_b  [4] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7};
        logic [31:0] v_hi [4] = '{32'hFFFF_FFFF, 32'd5, 32'd0, 32'd2};
        logic [31:0] v_lo [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd14};
        for (int i = 0; i < 14; i++) begin
            if (i < 4) begin
                sgn = (v_op[i] == 4'd12); a = v_a[i]; b = v_b[i]; q = {v_hi[i], v_lo[i]};
            end else begin
                sgn = 1'($urandom); a = rnd_opnd();
                b = ($urandom_range(0, 4) == 0) ? 32'd0 : rnd_opnd();
                q = div_ref(sgn, a, b);
            end
            send(sgn ? 12 : 13, a, b, 5'd6);
            n = 0;
            while (busy && n < 200) begin @(negedge clk); n++; end
            total++; if (n != 32 || out_valid !== 1'b1) begin bad++; $display("FAIL div_cycles got=%0d v=%b exp=32 v=1", n, out_valid); end
            m_hi = q[63:32]; m_lo = q[31:0];
            send(15, 32'd0, 32'd0, 5'd1);
            total++; if (result !== q[31:0]) begin bad++; $display("FAIL div_lo s=%0d a=%h b=%h got=%h exp=%h", sgn, a, b, result, q[31:0]); end
            send(14, 32'd0, 32'd0, 5'd1);
            total++; if (result !== q[63:32]) begin bad++; $display("FAIL div_hi s=%0d a=%h b=%h got=%h exp=%h", sgn, a, b, result, q[63:32]); end
        end
`else
        for (int i = 0; i < 4; i++) begin
            send(12 + (i % 2), rnd_opnd(), rnd_opnd(), 5'd17);
            total++; if (out_valid !== 1'b1 || overflow !== 1'b1 || out_dst !== 5'd0 || busy !== 1'b0) begin
                bad++; $display("FAIL divoff_flags got v=%b o=%b d=%0d busy=%b exp v=1 o=1 d=0 busy=0",
                                out_valid, overflow, out_dst, busy); end
            send(14, 32'd0, 32'd0, 5'd1);
            total++; if (result !== m_hi) begin bad++; $display("FAIL divoff_hi got=%h exp=%h", result, m_hi); end
            send(15, 32'd0, 32'd0, 5'd1);
            total++; if (result !== m_lo) begin bad++; $display("FAIL divoff_lo got=%h exp=%h", result, m_lo); end
        end
`endif
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        send(3, 32'd5, 32'd5, 5'd7);
        for (int k = 0; k < 4; k++) begin
            total++; if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || out_dst !== 5'd7 || overflow !== 1'b0) begin
                bad++; $display("FAIL bp_hold cyc=%0d got v=%b r=%h z=%b d=%0d o=%b exp v=1 r=0 z=1 d=7 o=0",
                                k, out_valid, result, zero, out_dst, overflow); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_consume got=%b exp=0", out_valid); end
        @(negedge clk);
    endtask

    task automatic test_reset_during_mul();
        send(11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        repeat (40) @(negedge clk);
        m_hi = 32'hFFFF_FFFE; m_lo = 32'h0000_0001;
        send(15, 32'd0, 32'd0, 5'd1);
        total++; if (result !== m_lo) begin bad++; $display("FAIL rstmul_pre_lo got=%h exp=%h", result, m_lo); end
        send(11, 32'h1234_5678, 32'h9ABC_DEF0, 5'd5);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL rstmul_abort got busy=%b v=%b exp 0 0", busy, out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0;
        send(15, 32'd0, 32'd0, 5'd1);
        total++; if (result !== 32'd0) begin bad++; $display("FAIL rstmul_lo got=%h exp=0", result); end
        send(14, 32'd0, 32'd0, 5'd1);
        total++; if (result !== 32'd0) begin bad++; $display("FAIL rstmul_hi got=%h exp=0", result); end
    endtask

    task automatic test_width16();
        int unsigned n;
        #1;
        total++; if (w_in_ready !== 1'b1) begin bad++; $display("FAIL w16_ready got=%b exp=1", w_in_ready); end
        w_in_valid = 1'b1; w_op = 4'd11; w_src_a = 16'hFFFF; w_src_b = 16'hFFFF; w_dst = 5'd8;
        @(posedge clk); #1; w_in_valid = 1'b0;
        @(negedge clk);
        n = 1;
        while (!w_out_valid && n < 200) begin @(negedge clk); n++; end
        total++; if (n != 17) begin bad++; $display("FAIL w16_latency got=%0d exp=17", n); end
        for (int i = 0; i < 2; i++) begin
            w_in_valid = 1'b1; w_op = (i == 0) ? 4'd14 : 4'd15;
            @(posedge clk); #1; w_in_valid = 1'b0;
            @(negedge clk);
            total++; if (w_result !== ((i == 0) ? 16'hFFFE : 16'h0001)) begin
                bad++; $display("FAIL w16_hilo sel=%0d got=%h exp=%h", i, w_result, (i == 0) ? 16'hFFFE : 16'h0001); end
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_alu_random();
        test_back_to_back();
        test_mult();
        test_mul_random();
        test_div();
        test_backpressure();
        test_reset_during_mul();
        test_width16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
